sonic_rx_chan_ctrl: RTL and testbench
=====================================

// Module: sonic_rx_chan_ctrl
// PURPOSE
//  Bring-up/recovery sequencer for one 66b SONIC RX channel (gearbox, blocksync, descrambler, CDC fifo).
//  Holds the datapath in reset until the transceiver is stable, then waits for block lock and settling.
//  Only after that does it open the fifo write/read enables.
//  Monitors sync-header errors (hi-BER) and lock loss, and re-sequences the channel on failure.
// PARAMETERS
//  READY_STABLE  16    cycles xcvr_rx_ready must stay high before chan_reset releases
//  LOCK_TIMEOUT  4096  cycles allowed after release to see block_lock before retry
//  SETTLE        64    consecutive locked cycles required before link_up
//  RESET_HOLD    8     cycles chan_reset held in S_HOLD (min 1)
//  BER_WINDOW    1024  hdr_valid samples per BER window
//  BER_THRESH    16    bad headers in one window that declare hi_ber
// PORTS
//  clk           in   1   datapath (rx wr) clock
//  reset         in   1   asynchronous, active-high reset
//  xcvr_rx_ready in   1   transceiver RX ready (already synchronous to clk)
//  block_lock    in   1   blocksync lock
//  hdr_valid     in   1   sync_header qualifies this cycle (gearbox valid)
//  sync_header   in   2   66b sync header; 2'b01/2'b10 good, 2'b00/2'b11 bad
//  chan_reset    out  1   reset to gearbox/blocksync/descrambler/fifo aclr
//  fifo_wr_en    out  1   gate for CDC fifo wrreq
//  fifo_rd_en    out  1   gate for CDC fifo rdreq (consumer resyncs it)
//  link_up       out  1   channel usable
//  hi_ber        out  1   sticky per-UP-session hi-BER flag
//  relock_count  out  16  saturating count of recoveries since reset
//  state         out  3   current state encoding (debug)
// BEHAVIOUR
//  Reset (async assert): state=S_HOLD, hold counter=0, chan_reset=1.
//   All other outputs reset to 0; relock_count=0. Deassertion is synchronised by the caller.
//  All outputs registered; they change the cycle after the state transition.
//  States (encoding):
//   S_HOLD(0): chan_reset=1. Counts RESET_HOLD cycles, then -> S_WAIT_XCVR.
//   S_WAIT_XCVR(1): chan_reset=1. Stable counter increments while xcvr_rx_ready=1 and clears to 0 when it is low.
//    When the counter reaches READY_STABLE -> S_WAIT_LOCK.
//   S_WAIT_LOCK(2): chan_reset=0. Timeout counter runs.
//    block_lock=1 -> S_SETTLE.
//    Counter reaches LOCK_TIMEOUT, or xcvr_rx_ready=0 -> S_HOLD (recovery).
//   S_SETTLE(3): counts consecutive block_lock=1 cycles. Reaching SETTLE -> S_UP.
//    block_lock=0 -> S_WAIT_LOCK with timeout restarted.
//    xcvr_rx_ready=0 -> S_HOLD.
//   S_UP(4): link_up=1, fifo_wr_en=1, fifo_rd_en=1.
//    block_lock=0, xcvr_rx_ready=0, or hi_ber set -> S_HOLD.
//  Recovery: every entry into S_HOLD from any state other than reset increments relock_count.
//   relock_count saturates at 16'hFFFF.
//  BER monitor: active only in S_UP.
//   Counts hdr_valid samples; counts bad headers on hdr_valid cycles only.
//   On the BER_WINDOW-th sample both counters clear (window roll).
//   Bad count reaching BER_THRESH within a window sets hi_ber the next cycle.
//   hi_ber clears only on entry to S_UP.
//   If the final window sample is also the threshold-reaching bad header, hi_ber is set (error counted before roll).
//   Bad counter saturates at BER_THRESH.
//  Simultaneous events: priority is xcvr_rx_ready loss > lock loss > hi_ber > timeout/count completion.
//  Leaving S_UP: link_up and both fifo enables drop the same cycle chan_reset rises (all registered together).
//  All counters are sized with $clog2(param+1) and never wrap.
// TESTING
//  Clean bring-up: xcvr_rx_ready=1 from t0, block_lock rises 20 cycles after chan_reset falls.
//   -> chan_reset low at cycle 8+16 (+1 reg); link_up after 64 more locked cycles; relock_count=0.
//  Unstable xcvr: xcvr_rx_ready toggles low at stable count 10.
//   -> counter restarts; chan_reset stays 1 until 16 consecutive high cycles.
//  Lock timeout: block_lock never rises.
//   -> after 4096 cycles in S_WAIT_LOCK: chan_reset=1, relock_count=1; cycle repeats, count=2 after second timeout.
//  Lock glitch in S_SETTLE at cycle 30 -> state returns to 2, no relock increment; link_up needs a full 64 fresh cycles.
//  hi-BER: in S_UP, inject 16 headers 2'b00 within 1024 samples.
//   -> hi_ber=1, state->S_HOLD, relock_count+1.
//   15 bad per window across many windows -> no hi_ber.
//  Async reset asserted mid-S_UP.
//   -> same cycle: chan_reset=1, link_up=0, relock_count=0, state=0.

Source files
------------

// File: rtl/sonic_rx_chan_ctrl.sv
// Bring-up / recovery sequencer for one 66b SONIC RX channel.
// Holds the gearbox/blocksync/descrambler/fifo in reset until the transceiver
// is stable, waits for block lock plus a settling period, then opens the CDC
// fifo enables. While up, it watches sync-header errors (hi-BER) and lock loss
// and re-sequences the channel on failure.
//
// Ports:
//   clk           datapath (rx write) clock
//   reset         asynchronous active-high reset
//   xcvr_rx_ready transceiver RX ready, already synchronous to clk
//   block_lock    blocksync lock
//   hdr_valid     sync_header qualifies this cycle
//   sync_header   66b sync header (01/10 good, 00/11 bad)
//   chan_reset    reset to the channel datapath
//   fifo_wr_en    CDC fifo write-request gate
//   fifo_rd_en    CDC fifo read-request gate
//   link_up       channel usable
//   hi_ber        sticky hi-BER flag for the current UP session
//   relock_count  saturating count of recoveries since reset
//   state         current state encoding (debug)
module sonic_rx_chan_ctrl #(
  parameter int unsigned READY_STABLE = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned SETTLE       = 64,
  parameter int unsigned RESET_HOLD   = 8,
  parameter int unsigned BER_WINDOW   = 1024,
  parameter int unsigned BER_THRESH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xcvr_rx_ready,
  input  logic        block_lock,
  input  logic        hdr_valid,
  input  logic [1:0]  sync_header,
  output logic        chan_reset,
  output logic        fifo_wr_en,
  output logic        fifo_rd_en,
  output logic        link_up,
  output logic        hi_ber,
  output logic [15:0] relock_count,
  output logic [2:0]  state
);

  localparam int unsigned HOLD_W   = $clog2(RESET_HOLD + 1);
  localparam int unsigned STABLE_W = $clog2(READY_STABLE + 1);
  localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
  localparam int unsigned SAMP_W   = $clog2(BER_WINDOW + 1);
  localparam int unsigned BAD_W    = $clog2(BER_THRESH + 1);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_XCVR = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_UP        = 3'd4
  } state_t;

  state_t cur_state, nxt_state;

  logic [HOLD_W-1:0]   hold_cnt,   hold_cnt_d;
  logic [STABLE_W-1:0] stable_cnt, stable_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt,    tmo_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_d;
  logic [SAMP_W-1:0]   samp_cnt,   samp_cnt_d;
  logic [BAD_W-1:0]    bad_cnt,    bad_cnt_d;
  logic [BAD_W-1:0]    bad_sum;
  logic                hdr_bad;

  logic        chan_reset_d;
  logic        link_up_d;
  logic        hi_ber_d;
  logic [15:0] relock_d;

  assign hdr_bad = (sync_header == 2'b00) || (sync_header == 2'b11);

  // Next state, counters and next registered outputs.
  // Counters default to zero so every state entry starts them fresh.
  always_comb begin
    nxt_state    = cur_state;
    hold_cnt_d   = '0;
    stable_cnt_d = '0;
    tmo_cnt_d    = '0;
    settle_cnt_d = '0;
    samp_cnt_d   = '0;
    bad_cnt_d    = '0;
    bad_sum      = bad_cnt;
    hi_ber_d     = hi_ber;
    relock_d     = relock_count;
    chan_reset_d = 1'b1;
    link_up_d    = 1'b0;

    case (cur_state)
      S_HOLD: begin
        if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) nxt_state = S_WAIT_XCVR;
        else                                      hold_cnt_d = hold_cnt + HOLD_W'(1);
      end

      S_WAIT_XCVR: begin
        if (xcvr_rx_ready) begin
          if (stable_cnt == STABLE_W'(READY_STABLE - 1)) nxt_state = S_WAIT_LOCK;
          else stable_cnt_d = stable_cnt + STABLE_W'(1);
        end
      end

      S_WAIT_LOCK: begin
        if (!xcvr_rx_ready)                           nxt_state = S_HOLD;
        else if (block_lock)                          nxt_state = S_SETTLE;
        else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) nxt_state = S_HOLD;
        else                                          tmo_cnt_d = tmo_cnt + TMO_W'(1);
      end

      S_SETTLE: begin
        if (!xcvr_rx_ready)                                nxt_state = S_HOLD;
        else if (!block_lock)                              nxt_state = S_WAIT_LOCK;
        else if (settle_cnt == SETTLE_W'(SETTLE - 1))      nxt_state = S_UP;
        else                                               settle_cnt_d = settle_cnt + SETTLE_W'(1);
      end

      S_UP: begin
        if (!xcvr_rx_ready || !block_lock || hi_ber) nxt_state = S_HOLD;

        // BER window: the error on the last sample is counted before the roll.
        samp_cnt_d = samp_cnt;
        bad_cnt_d  = bad_cnt;
        if (hdr_valid) begin
          if (hdr_bad && (bad_cnt != BAD_W'(BER_THRESH))) bad_sum = bad_cnt + BAD_W'(1);
          if (hdr_bad && (bad_sum == BAD_W'(BER_THRESH))) hi_ber_d = 1'b1;
          if (samp_cnt == SAMP_W'(BER_WINDOW - 1)) begin
            samp_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            samp_cnt_d = samp_cnt + SAMP_W'(1);
            bad_cnt_d  = bad_sum;
          end
        end
      end

      default: nxt_state = S_HOLD;
    endcase

    if ((nxt_state == S_HOLD) && (cur_state != S_HOLD) && (relock_count != 16'hFFFF))
      relock_d = relock_count + 16'd1;

    if ((nxt_state == S_UP) && (cur_state != S_UP))
      hi_ber_d = 1'b0;

    chan_reset_d = (nxt_state == S_HOLD) || (nxt_state == S_WAIT_XCVR);
    link_up_d    = (nxt_state == S_UP);
  end

  // State, counters and outputs; outputs follow the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state    <= S_HOLD;
      hold_cnt     <= '0;
      stable_cnt   <= '0;
      tmo_cnt      <= '0;
      settle_cnt   <= '0;
      samp_cnt     <= '0;
      bad_cnt      <= '0;
      chan_reset   <= 1'b1;
      link_up      <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      hi_ber       <= 1'b0;
      relock_count <= '0;
    end else begin
      cur_state    <= nxt_state;
      hold_cnt     <= hold_cnt_d;
      stable_cnt   <= stable_cnt_d;
      tmo_cnt      <= tmo_cnt_d;
      settle_cnt   <= settle_cnt_d;
      samp_cnt     <= samp_cnt_d;
      bad_cnt      <= bad_cnt_d;
      chan_reset   <= chan_reset_d;
      link_up      <= link_up_d;
      fifo_wr_en   <= link_up_d;
      fifo_rd_en   <= link_up_d;
      hi_ber       <= hi_ber_d;
      relock_count <= relock_d;
    end
  end

  assign state = 3'(cur_state);

endmodule

// File: tb/tb_sonic_rx_chan_ctrl.sv
// Scoreboard bench for sonic_rx_chan_ctrl: every change of the output bundle
// is an event that must match the next expected event (cycle and values).
module tb_sonic_rx_chan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        xcvr_rx_ready;
  logic        block_lock;
  logic        hdr_valid;
  logic [1:0]  sync_header;
  logic        chan_reset;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic        link_up;
  logic        hi_ber;
  logic [15:0] relock_count;
  logic [2:0]  state;

  sonic_rx_chan_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .xcvr_rx_ready (xcvr_rx_ready),
    .block_lock    (block_lock),
    .hdr_valid     (hdr_valid),
    .sync_header   (sync_header),
    .chan_reset    (chan_reset),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_rd_en    (fifo_rd_en),
    .link_up       (link_up),
    .hi_ber        (hi_ber),
    .relock_count  (relock_count),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Rising edges since reset was last released.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          c;
    logic [2:0]  st;
    logic        cr;
    logic        lu;
    logic        hb;
    logic [15:0] rc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic push_ev(input int c, input logic [2:0] st, input logic cr,
                         input logic lu, input logic hb, input logic [15:0] rc);
    ev_t e;
    e.c = c; e.st = st; e.cr = cr; e.lu = lu; e.hb = hb; e.rc = rc;
    exp_q.push_back(e);
  endtask

  // Advance to the falling edge that follows rising edge n.
  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
    if (cyc != n) begin
      failures++;
      $display("FAIL goto: at cycle %0d, wanted cycle %0d", cyc, n);
    end
  endtask

  function automatic logic is_bad(input int s);
    return (s >= 1010 && s <= 1039) || (s >= 2049 && s <= 2063) ||
           (s >= 3073 && s <= 3087) || (s == 4096);
  endfunction

  // Monitor: any change of the output bundle pops and compares one event.
  logic [23:0] obs;
  logic [23:0] last_obs = 'x;
  logic [23:0] want;
  ev_t         e_got;
  always @(negedge clk) begin
    obs = {state, chan_reset, link_up, fifo_wr_en, fifo_rd_en, hi_ber, relock_count};
    if (obs !== last_obs) begin
      last_obs = obs;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: cycle=%0d state=%0d cr=%b lu=%b wr=%b rd=%b hb=%b rc=%0d",
                 cyc, state, chan_reset, link_up, fifo_wr_en, fifo_rd_en, hi_ber, relock_count);
      end else begin
        e_got = exp_q.pop_front();
        want  = {e_got.st, e_got.cr, e_got.lu, e_got.lu, e_got.lu, e_got.hb, e_got.rc};
        if (obs !== want || cyc != e_got.c) begin
          failures++;
          $display("FAIL event: got cycle=%0d state=%0d cr=%b lu=%b wr=%b rd=%b hb=%b rc=%0d; want cycle=%0d state=%0d cr=%b lu=%b hb=%b rc=%0d",
                   cyc, state, chan_reset, link_up, fifo_wr_en, fifo_rd_en, hi_ber, relock_count,
                   e_got.c, e_got.st, e_got.cr, e_got.lu, e_got.hb, e_got.rc);
        end
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; xcvr_rx_ready = 1'b1; block_lock = 1'b0;
    hdr_valid = 1'b0; sync_header = 2'b01;

    // Clean bring-up, lock 20 cycles after chan_reset falls.
    push_ev(0,   3'd0, 1, 0, 0, 16'd0);
    push_ev(8,   3'd1, 1, 0, 0, 16'd0);
    push_ev(24,  3'd2, 0, 0, 0, 16'd0);
    push_ev(45,  3'd3, 0, 0, 0, 16'd0);
    push_ev(109, 3'd4, 0, 1, 0, 16'd0);
    // hi-BER: 16 bad headers in one window.
    push_ev(136, 3'd4, 0, 1, 1, 16'd0);
    push_ev(137, 3'd0, 1, 0, 1, 16'd1);
    push_ev(145, 3'd1, 1, 0, 1, 16'd1);
    push_ev(161, 3'd2, 0, 0, 1, 16'd1);
    push_ev(162, 3'd3, 0, 0, 1, 16'd1);
    push_ev(226, 3'd4, 0, 1, 0, 16'd1);
    // 15 bad per window (incl. across a roll), then 16th bad on the last sample.
    push_ev(4322, 3'd4, 0, 1, 1, 16'd1);
    push_ev(4323, 3'd0, 1, 0, 1, 16'd2);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    goto(44);  block_lock = 1'b1;
    goto(109); hdr_valid = 1'b1;
    goto(120); sync_header = 2'b00;
    goto(136); sync_header = 2'b01;

    for (int s = 1; s <= 4096; s++) begin
      goto(225 + s);
      if (is_bad(s)) sync_header = s[0] ? 2'b00 : 2'b11;
      else           sync_header = s[0] ? 2'b01 : 2'b10;
    end
    goto(4322); hdr_valid = 1'b0; sync_header = 2'b01;

    // Unstable xcvr, then lock glitch in settle, then lock loss in UP.
    push_ev(4331, 3'd1, 1, 0, 1, 16'd2);
    push_ev(4358, 3'd2, 0, 0, 1, 16'd2);
    push_ev(4359, 3'd3, 0, 0, 1, 16'd2);
    push_ev(4390, 3'd2, 0, 0, 1, 16'd2);
    push_ev(4391, 3'd3, 0, 0, 1, 16'd2);
    push_ev(4455, 3'd4, 0, 1, 0, 16'd2);
    push_ev(4466, 3'd0, 1, 0, 0, 16'd3);
    push_ev(4474, 3'd1, 1, 0, 0, 16'd3);
    push_ev(4490, 3'd2, 0, 0, 0, 16'd3);
    push_ev(4491, 3'd3, 0, 0, 0, 16'd3);
    push_ev(4555, 3'd4, 0, 1, 0, 16'd3);
    goto(4323); xcvr_rx_ready = 1'b0;
    goto(4331); xcvr_rx_ready = 1'b1;
    goto(4341); xcvr_rx_ready = 1'b0;
    goto(4342); xcvr_rx_ready = 1'b1;
    goto(4389); block_lock = 1'b0;
    goto(4390); block_lock = 1'b1;
    goto(4465); block_lock = 1'b0;
    goto(4466); block_lock = 1'b1;

    // Async reset in the middle of UP.
    push_ev(0, 3'd0, 1, 0, 0, 16'd0);
    goto(4560);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ready and lock lost together in settle: ready loss wins (-> HOLD).
    push_ev(8,  3'd1, 1, 0, 0, 16'd0);
    push_ev(24, 3'd2, 0, 0, 0, 16'd0);
    push_ev(25, 3'd3, 0, 0, 0, 16'd0);
    push_ev(31, 3'd0, 1, 0, 0, 16'd1);
    // Two lock timeouts, then ready loss in WAIT_LOCK.
    push_ev(39,   3'd1, 1, 0, 0, 16'd1);
    push_ev(55,   3'd2, 0, 0, 0, 16'd1);
    push_ev(4151, 3'd0, 1, 0, 0, 16'd2);
    push_ev(4159, 3'd1, 1, 0, 0, 16'd2);
    push_ev(4175, 3'd2, 0, 0, 0, 16'd2);
    push_ev(8271, 3'd0, 1, 0, 0, 16'd3);
    push_ev(8279, 3'd1, 1, 0, 0, 16'd3);
    push_ev(8295, 3'd2, 0, 0, 0, 16'd3);
    push_ev(8301, 3'd0, 1, 0, 0, 16'd4);
    push_ev(8309, 3'd1, 1, 0, 0, 16'd4);
    goto(30); xcvr_rx_ready = 1'b0; block_lock = 1'b0;
    goto(31); xcvr_rx_ready = 1'b1;
    goto(8300); xcvr_rx_ready = 1'b0;
    goto(8320);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
